seg7_msg_scanner: RTL and testbench

//  Parametrised multiplexed 7-segment driver: scans NUM_DIGITS digits, shows a status word
//  (" On ", " OFF", " Err", "OPEn") chosen by priority from status inputs, or a user-written
//  raw-pattern buffer. Adds frame-synchronous message switching, Err blink, PWM brightness.

---
 rtl/seg7_msg_scanner.sv | 152 +++++++++++++++
 tb/tb_seg7_msg_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_msg_scanner.sv
// Multiplexed 7-segment scanner: status words or a user pattern buffer, with
// frame-synchronous message switching, Err blink and per-slot PWM brightness.
module seg7_msg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_TICKS  = 50000,
    parameter int BLINK_FRAMES = 125,
    parameter bit BLINK_EN     = 1'b1
) (
    input  logic                  clk_50MHz,
    input  logic                  reset_button_n,
    input  logic                  result_on,
    input  logic                  result_off,
    input  logic                  result_err,
    input  logic                  result_open,
    input  logic                  usr_mode,
    input  logic                  usr_we,
    input  logic [2:0]            usr_addr,
    input  logic [7:0]            usr_data,
    input  logic [2:0]            brightness,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] digit,
    output logic                  frame_tick
);

    localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [2:0] MSG_BLANK = 3'd0;
    localparam logic [2:0] MSG_ON    = 3'd1;
    localparam logic [2:0] MSG_OFF   = 3'd2;
    localparam logic [2:0] MSG_ERR   = 3'd3;
    localparam logic [2:0] MSG_OPEN  = 3'd4;
    localparam logic [2:0] MSG_USER  = 3'd5;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    logic [CW-1:0] slot_cnt;
    logic [IW-1:0] digit_idx;
    logic [2:0]    active_msg;
    logic [2:0]    next_msg;
    logic          blink_off;
    logic [BW-1:0] blink_cnt;
    logic [2:0]    bright_q;
    logic [2:0]    bright_eff;
    logic [7:0]    user_buf [NUM_DIGITS];

    logic          slot_end;
    logic          frame_end;
    logic          lit;
    logic [31:0]   duty_limit;
    logic [31:0]   word;
    logic [1:0]    word_idx;
    logic [7:0]    glyph;

    always_comb begin
        slot_end  = (32'(slot_cnt) == DIGIT_TICKS - 1);
        frame_end = slot_end && (32'(digit_idx) == NUM_DIGITS - 1);

        if (result_err)       next_msg = MSG_ERR;
        else if (result_open) next_msg = MSG_OPEN;
        else if (result_off)  next_msg = MSG_OFF;
        else if (result_on)   next_msg = MSG_ON;
        else if (usr_mode)    next_msg = MSG_USER;
        else                  next_msg = MSG_BLANK;

        // The first tick of a slot uses the live input; later ticks use its latched copy.
        bright_eff = (slot_cnt == '0) ? brightness : bright_q;
        duty_limit = ((32'(bright_eff) + 32'd1) * 32'(DIGIT_TICKS)) >> 3;
        lit        = (32'(slot_cnt) < duty_limit);

        // Status words packed digit3..digit0, most significant byte first.
        case (active_msg)
            MSG_ON:   word = 32'hFF03D5FF;
            MSG_OFF:  word = 32'hFF037171;
            MSG_ERR:  word = 32'hFF61F5F5;
            MSG_OPEN: word = 32'h033161D5;
            default:  word = '1;
        endcase

        word_idx = digit_idx[1:0];
        glyph    = SEG_BLANK;
        if (active_msg == MSG_USER)
            glyph = user_buf[digit_idx];
        else if (32'(digit_idx) < 4)
            glyph = word[{word_idx, 3'b000} +: 8];
    end

    always_ff @(posedge clk_50MHz or negedge reset_button_n) begin
        if (!reset_button_n) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            bright_q   <= '1;
            active_msg <= MSG_BLANK;
        end else begin
            if (slot_cnt == '0)
                bright_q <= brightness;
            if (slot_end) begin
                slot_cnt <= '0;
                if (32'(digit_idx) == NUM_DIGITS - 1)
                    digit_idx <= '0;
                else
                    digit_idx <= digit_idx + IW'(1);
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end
            if (frame_end)
                active_msg <= next_msg;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_button_n) begin
        if (!reset_button_n) begin
            blink_off <= 1'b0;
            blink_cnt <= '0;
        end else if (frame_end) begin
            if (BLINK_EN && active_msg == MSG_ERR && next_msg == MSG_ERR) begin
                if (32'(blink_cnt) == BLINK_FRAMES - 1) begin
                    blink_off <= ~blink_off;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                blink_off <= 1'b0;
                blink_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_button_n) begin
        if (!reset_button_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
                user_buf[i] <= SEG_BLANK;
        end else if (usr_we && (32'(usr_addr) < NUM_DIGITS)) begin
            user_buf[usr_addr[IW-1:0]] <= usr_data;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_button_n) begin
        if (!reset_button_n) begin
            seg        <= SEG_BLANK;
            digit      <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg        <= (lit && !blink_off) ? glyph : SEG_BLANK;
            digit      <= lit ? (NUM_DIGITS'(1) << digit_idx) : '0;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_msg_scanner.sv
// Randomized bench for seg7_msg_scanner against a cycle-indexed reference model.
module tb_seg7_msg_scanner;

    localparam int ND    = 4;
    localparam int DT    = 8;
    localparam int BF    = 2;
    localparam int FRAME = ND * DT;

    logic          clk_50MHz = 1'b0;
    logic          reset_button_n;
    logic          result_on, result_off, result_err, result_open;
    logic          usr_mode, usr_we;
    logic [2:0]    usr_addr;
    logic [7:0]    usr_data;
    logic [2:0]    brightness;
    logic [7:0]    seg;
    logic [ND-1:0] digit;
    logic          frame_tick;

    seg7_msg_scanner #(
        .NUM_DIGITS  (ND),
        .DIGIT_TICKS (DT),
        .BLINK_FRAMES(BF),
        .BLINK_EN    (1'b1)
    ) dut (
        .clk_50MHz     (clk_50MHz),
        .reset_button_n(reset_button_n),
        .result_on     (result_on),
        .result_off    (result_off),
        .result_err    (result_err),
        .result_open   (result_open),
        .usr_mode      (usr_mode),
        .usr_we        (usr_we),
        .usr_addr      (usr_addr),
        .usr_data      (usr_data),
        .brightness    (brightness),
        .seg           (seg),
        .digit         (digit),
        .frame_tick    (frame_tick)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: edges since reset, message per frame, Err run length.
    int         n;
    int         msg_m;      // 0 blank, 1 On, 2 OFF, 3 Err, 4 OPEn, 5 user
    int         err_run;
    int         bright_m;
    logic [7:0] buf_m [8];

    function automatic int pick_msg();
        if (result_err)  return 3;
        if (result_open) return 4;
        if (result_off)  return 2;
        if (result_on)   return 1;
        if (usr_mode)    return 5;
        return 0;
    endfunction

    function automatic logic [7:0] word_glyph(input int msg, input int idx);
        logic [31:0] w;
        case (msg)
            1:       w = 32'hFF03D5FF;
            2:       w = 32'hFF037171;
            3:       w = 32'hFF61F5F5;
            4:       w = 32'h033161D5;
            default: w = 32'hFFFFFFFF;
        endcase
        return 8'((w >> (8 * idx)) & 32'hFF);
    endfunction

    task automatic model_reset();
        n        = 0;
        msg_m    = 0;
        err_run  = 0;
        bright_m = 7;
        for (int i = 0; i < 8; i++) buf_m[i] = 8'hFF;
    endtask

    // Called right at a rising edge; predicts the registered outputs, then checks #1 later.
    task automatic step_and_check();
        int         s, idx;
        bit         lit, off, ft;
        logic [7:0] g, exp_seg;
        logic [3:0] exp_dig;
        s   = n % DT;
        idx = (n / DT) % ND;
        if (s == 0) bright_m = int'(brightness);
        lit = (s < (((bright_m + 1) * DT) >> 3));
        off = (msg_m == 3) && ((((err_run - 1) / BF) % 2) == 1);
        if (msg_m == 5)      g = buf_m[idx];
        else if (msg_m == 0) g = 8'hFF;
        else                 g = word_glyph(msg_m, idx);
        exp_seg = (lit && !off) ? g : 8'hFF;
        exp_dig = lit ? 4'(1 << idx) : 4'd0;
        ft      = (s == DT - 1) && (idx == ND - 1);
        if (usr_we && usr_addr < ND) buf_m[usr_addr] = usr_data;
        if (ft) begin
            msg_m   = pick_msg();
            err_run = (msg_m == 3) ? err_run + 1 : 0;
        end
        n++;
        #1;
        check_val("seg",        32'(seg),        32'(exp_seg));
        check_val("digit",      32'(digit),      32'(exp_dig));
        check_val("frame_tick", 32'(frame_tick), 32'(ft));
    endtask

    // prof: 0 idle, 1 all random, 2 err held, 3 user buffer, 4 open held
    task automatic drive(input int prof);
        result_on   = 1'b0; result_off = 1'b0; result_err = 1'b0; result_open = 1'b0;
        usr_mode    = 1'b0; usr_we     = 1'b0;
        usr_addr    = 3'($urandom_range(0, 7));
        usr_data    = 8'($urandom);
        brightness  = 3'd7;
        case (prof)
            1: begin
                result_on   = ($urandom_range(0, 3) == 0);
                result_off  = ($urandom_range(0, 3) == 0);
                result_err  = ($urandom_range(0, 3) == 0);
                result_open = ($urandom_range(0, 3) == 0);
                usr_mode    = 1'($urandom);
                usr_we      = 1'($urandom);
                brightness  = 3'($urandom);
            end
            2: begin
                result_err = 1'b1;
                result_on  = 1'($urandom);
                result_off = 1'($urandom);
                usr_mode   = 1'($urandom);
            end
            3: begin
                usr_mode   = 1'b1;
                usr_we     = ($urandom_range(0, 3) == 0);
                brightness = 3'($urandom);
            end
            4: begin
                result_open = 1'b1;
                result_on   = 1'($urandom);
            end
            default: ;
        endcase
    endtask

    task automatic run(input int frames, input int prof);
        repeat (frames * FRAME) begin
            @(posedge clk_50MHz);
            step_and_check();
            drive(prof);
        end
    endtask

    initial begin
        reset_button_n = 1'b0;
        drive(0);
        model_reset();
        #25;
        check_val("rst_seg",   32'(seg),        32'hFF);
        check_val("rst_digit", 32'(digit),      32'h0);
        check_val("rst_ft",    32'(frame_tick), 32'h0);
        @(posedge clk_50MHz);
        #1;
        reset_button_n = 1'b1;

        run(4, 0);
        run(40, 1);
        run(12, 2);
        run(3, 4);
        run(12, 3);
        run(15, 1);

        // Park 13 clocks into a frame, then reset asynchronously mid-slot.
        for (int k = 0; k < FRAME && (n % FRAME) != 13; k++) begin
            @(posedge clk_50MHz);
            step_and_check();
            drive(1);
        end
        #3;
        reset_button_n = 1'b0;
        #1;
        check_val("arst_seg",   32'(seg),        32'hFF);
        check_val("arst_digit", 32'(digit),      32'h0);
        check_val("arst_ft",    32'(frame_tick), 32'h0);
        @(posedge clk_50MHz);
        #1;
        check_val("arst_hold_digit", 32'(digit), 32'h0);
        reset_button_n = 1'b1;
        model_reset();

        run(6, 3);
        run(10, 2);
        run(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
